// File: rtl/cricket_pkg.sv
// Shared constants, widths and FSM state for the cricket scoreboard.
// Imported by the scorer and by the display stage.
package cricket_pkg;

  localparam int OVERS          = 20;
  localparam int BALLS_PER_OVER = 6;
  localparam int MAX_WICKETS    = 10;
  localparam int RUN_SAT        = 999;

  localparam int RUNS_W = 10;
  localparam int WKT_W  = 4;
  localparam int OVR_W  = 5;
  localparam int BALL_W = 3;
  localparam int SEL_W  = 3;

  typedef enum logic [0:0] {
    PLAY = 1'b0,
    DONE = 1'b1
  } state_e;

endpackage

// File: rtl/pulse_sync.sv
// Two-flop synchroniser plus rising-edge detector.
// Ports: clk_fpga, reset_n (async low), in (async level), pulse (1 cycle).
module pulse_sync (
  input  logic clk_fpga,
  input  logic reset_n,
  input  logic in,
  output logic pulse
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk_fpga or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign pulse = s2_q & ~s3_q;

endmodule

// File: rtl/ball_event_scorer.sv
// Turns each debounced ball press into one scored T20 delivery.
// Ports: clk_fpga, reset_n, debounced_button, new_innings, run_sel,
//   wicket, extra in; runs, wickets, overs, balls, innings_over,
//   ball_event, bad_input out.
module ball_event_scorer
  import cricket_pkg::*;
#(
  parameter int OVERS          = cricket_pkg::OVERS,
  parameter int BALLS_PER_OVER = cricket_pkg::BALLS_PER_OVER,
  parameter int MAX_WICKETS    = cricket_pkg::MAX_WICKETS,
  parameter int RUN_SAT        = cricket_pkg::RUN_SAT
) (
  input  logic              clk_fpga,
  input  logic              reset_n,
  input  logic              debounced_button,
  input  logic              new_innings,
  input  logic [SEL_W-1:0]  run_sel,
  input  logic              wicket,
  input  logic              extra,
  output logic [RUNS_W-1:0] runs,
  output logic [WKT_W-1:0]  wickets,
  output logic [OVR_W-1:0]  overs,
  output logic [BALL_W-1:0] balls,
  output logic              innings_over,
  output logic              ball_event,
  output logic              bad_input
);

  logic evt;

  pulse_sync u_sync (
    .clk_fpga (clk_fpga),
    .reset_n  (reset_n),
    .in       (debounced_button),
    .pulse    (evt)
  );

  state_e              state_q, state_d;
  logic [RUNS_W-1:0]   runs_q, runs_d;
  logic [WKT_W-1:0]    wkt_q, wkt_d;
  logic [OVR_W-1:0]    ovr_q, ovr_d;
  logic [BALL_W-1:0]   ball_q, ball_d;
  logic                bev_q, bev_d;
  logic                bad_q, bad_d;
  logic [RUNS_W:0]     run_sum;

  // One extra bit so the sum can exceed the cap before clamping.
  assign run_sum = {1'b0, runs_q}
                 + (RUNS_W+1)'(run_sel)
                 + (RUNS_W+1)'(extra);

  always_comb begin
    state_d = state_q;
    runs_d  = runs_q;
    wkt_d   = wkt_q;
    ovr_d   = ovr_q;
    ball_d  = ball_q;
    bev_d   = 1'b0;
    bad_d   = 1'b0;
    if (new_innings) begin
      state_d = PLAY;
      runs_d  = '0;
      wkt_d   = '0;
      ovr_d   = '0;
      ball_d  = '0;
    end else if (evt && state_q == PLAY) begin
      if (run_sel == 3'd7) begin
        bad_d = 1'b1;
      end else begin
        bev_d = 1'b1;
        if (run_sum > (RUNS_W+1)'(RUN_SAT))
          runs_d = RUNS_W'(RUN_SAT);
        else
          runs_d = run_sum[RUNS_W-1:0];
        if (!extra) begin
          if (wicket && wkt_q < WKT_W'(MAX_WICKETS))
            wkt_d = wkt_q + 1'b1;
          if (ball_q == BALL_W'(BALLS_PER_OVER - 1)) begin
            ball_d = '0;
            if (ovr_q < OVR_W'(OVERS))
              ovr_d = ovr_q + 1'b1;
          end else begin
            ball_d = ball_q + 1'b1;
          end
          if (wkt_d >= WKT_W'(MAX_WICKETS) ||
              ovr_d >= OVR_W'(OVERS))
            state_d = DONE;
        end
      end
    end
  end

  always_ff @(posedge clk_fpga or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PLAY;
      runs_q  <= '0;
      wkt_q   <= '0;
      ovr_q   <= '0;
      ball_q  <= '0;
      bev_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      runs_q  <= runs_d;
      wkt_q   <= wkt_d;
      ovr_q   <= ovr_d;
      ball_q  <= ball_d;
      bev_q   <= bev_d;
      bad_q   <= bad_d;
    end
  end

  assign runs         = runs_q;
  assign wickets      = wkt_q;
  assign overs        = ovr_q;
  assign balls        = ball_q;
  assign innings_over = (state_q == DONE);
  assign ball_event   = bev_q;
  assign bad_input    = bad_q;

endmodule

// File: tb/tb_ball_event_scorer.sv
// Directed bench for ball_event_scorer.
// Hand-computed expectations, one checking task.
module tb_ball_event_scorer;

  logic       clk_fpga = 1'b0;
  logic       reset_n;
  logic       debounced_button;
  logic       new_innings;
  logic [2:0] run_sel;
  logic       wicket;
  logic       extra;
  logic [9:0] runs;
  logic [3:0] wickets;
  logic [4:0] overs;
  logic [2:0] balls;
  logic       innings_over;
  logic       ball_event;
  logic       bad_input;

  int n_chk  = 0;
  int n_fail = 0;
  int ev_cnt = 0;
  int bad_cnt = 0;
  int ev0, bad0;

  always #5 clk_fpga = ~clk_fpga;

  ball_event_scorer dut (
    .clk_fpga         (clk_fpga),
    .reset_n          (reset_n),
    .debounced_button (debounced_button),
    .new_innings      (new_innings),
    .run_sel          (run_sel),
    .wicket           (wicket),
    .extra            (extra),
    .runs             (runs),
    .wickets          (wickets),
    .overs            (overs),
    .balls            (balls),
    .innings_over     (innings_over),
    .ball_event       (ball_event),
    .bad_input        (bad_input)
  );

  always @(negedge clk_fpga) begin
    if (ball_event) ev_cnt++;
    if (bad_input)  bad_cnt++;
  end

  task automatic check(input string tag,
                       input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic press(input int sel, input bit w,
                       input bit x, input int hold);
    @(negedge clk_fpga);
    run_sel = 3'(sel);
    wicket  = w;
    extra   = x;
    debounced_button = 1'b1;
    repeat (hold) @(negedge clk_fpga);
    debounced_button = 1'b0;
    repeat (5) @(negedge clk_fpga);
  endtask

  task automatic clear();
    @(negedge clk_fpga);
    new_innings = 1'b1;
    @(negedge clk_fpga);
    new_innings = 1'b0;
    @(negedge clk_fpga);
  endtask

  task automatic chk_score(input string tag, input int r, input int wk,
                           input int ov, input int b, input int io);
    check({tag, ".runs"}, int'(runs), r);
    check({tag, ".wkts"}, int'(wickets), wk);
    check({tag, ".overs"}, int'(overs), ov);
    check({tag, ".balls"}, int'(balls), b);
    check({tag, ".done"}, int'(innings_over), io);
  endtask

  initial begin
    reset_n = 1'b0;
    debounced_button = 1'b0;
    new_innings = 1'b0;
    run_sel = '0;
    wicket = 1'b0;
    extra = 1'b0;
    repeat (3) @(negedge clk_fpga);
    chk_score("reset", 0, 0, 0, 0, 0);
    check("reset.bev", int'(ball_event), 0);
    check("reset.bad", int'(bad_input), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_fpga);

    // first press: exact edge-3 timing
    run_sel = 3'd4;
    debounced_button = 1'b1;
    @(posedge clk_fpga); #1;
    check("t1.e1.runs", int'(runs), 0);
    @(posedge clk_fpga); #1;
    check("t1.e2.bev", int'(ball_event), 0);
    @(posedge clk_fpga); #1;
    check("t1.e3.runs", int'(runs), 4);
    check("t1.e3.balls", int'(balls), 1);
    check("t1.e3.bev", int'(ball_event), 1);
    @(posedge clk_fpga); #1;
    check("t1.e4.bev", int'(ball_event), 0);
    debounced_button = 1'b0;
    repeat (4) @(negedge clk_fpga);

    // six legal singles complete an over
    clear();
    chk_score("clr1", 0, 0, 0, 0, 0);
    ev0 = ev_cnt;
    for (int i = 0; i < 6; i++) press(1, 1'b0, 1'b0, 2);
    chk_score("over", 6, 0, 1, 0, 0);
    check("over.events", ev_cnt - ev0, 6);

    // long hold gives exactly one event
    ev0 = ev_cnt;
    press(0, 1'b0, 1'b0, 10000);
    check("hold.events", ev_cnt - ev0, 1);
    chk_score("hold", 6, 0, 1, 1, 0);

    // extra: 1 + run_sel, wicket ignored, ball not counted
    press(2, 1'b1, 1'b1, 1);
    chk_score("extra", 9, 0, 1, 1, 0);

    // ten wickets end the innings (11 legal balls -> 2.5 overs)
    for (int i = 0; i < 10; i++) press(0, 1'b1, 1'b0, 1);
    chk_score("allout", 9, 10, 2, 5, 1);
    ev0 = ev_cnt; bad0 = bad_cnt;
    press(3, 1'b1, 1'b0, 1);
    chk_score("frozen", 9, 10, 2, 5, 1);
    check("frozen.ev", ev_cnt - ev0, 0);
    check("frozen.bad", bad_cnt - bad0, 0);

    // saturation: 142 * 7 + 4 = 998 via extras
    clear();
    chk_score("clr2", 0, 0, 0, 0, 0);
    for (int i = 0; i < 142; i++) press(6, 1'b0, 1'b1, 1);
    press(3, 1'b0, 1'b1, 1);
    chk_score("pre998", 998, 0, 0, 0, 0);
    press(6, 1'b0, 1'b0, 1);
    chk_score("sat", 999, 0, 0, 1, 0);
    press(6, 1'b0, 1'b1, 1);
    chk_score("sat2", 999, 0, 0, 1, 0);

    // invalid run_sel
    ev0 = ev_cnt; bad0 = bad_cnt;
    press(7, 1'b1, 1'b0, 1);
    chk_score("bad", 999, 0, 0, 1, 0);
    check("bad.strobe", bad_cnt - bad0, 1);
    check("bad.noev", ev_cnt - ev0, 0);

    // clear collides with an event: clear wins
    clear();
    press(5, 1'b1, 1'b0, 1);
    chk_score("precoll", 5, 1, 0, 1, 0);
    ev0 = ev_cnt;
    @(negedge clk_fpga);
    run_sel = 3'd3;
    wicket = 1'b0;
    extra = 1'b0;
    debounced_button = 1'b1;
    repeat (2) @(negedge clk_fpga);
    new_innings = 1'b1;
    @(negedge clk_fpga);
    new_innings = 1'b0;
    debounced_button = 1'b0;
    repeat (4) @(negedge clk_fpga);
    chk_score("coll", 0, 0, 0, 0, 0);
    check("coll.ev", ev_cnt - ev0, 0);

    // async reset mid-over
    press(2, 1'b0, 1'b0, 1);
    press(1, 1'b1, 1'b0, 1);
    chk_score("premid", 3, 1, 0, 2, 0);
    @(negedge clk_fpga);
    #2 reset_n = 1'b0;
    #1;
    chk_score("async", 0, 0, 0, 0, 0);
    @(negedge clk_fpga);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_fpga);
    chk_score("post", 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ball_event_scorer.md
# ball_event_scorer

Consumes the debounced ball-switch pulse from the debounce stage and turns each press into one scored delivery for a T20 innings. Samples the outcome switches (runs, wicket, extra) at each delivery and maintains runs, wickets, overs and balls-in-over for the display stage. Detects end of innings (all out or overs exhausted) and then freezes the score until a new innings is started.

## Interface
Parameters:
- OVERS, 20: overs per innings.
- BALLS_PER_OVER, 6: legal deliveries per over.
- MAX_WICKETS, 10: wickets that end the innings.
- RUN_SAT, 999: run total saturation value, sized for the 3-digit display.

Ports (one clock; reset is asynchronous and active-low):
- clk_fpga  in  1  board clock; all state on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- debounced_button  in  1  debounced ball switch, high for one 10 Hz period per press; treated as asynchronous to clk_fpga.
- new_innings  in  1  synchronous clear; level-sensitive.
- run_sel  in  3  runs off the bat, 0–6; value 7 is invalid.
- wicket  in  1  wicket fell on this delivery.
- extra  in  1  wide/no-ball on this delivery.
- runs  out  10  run total.
- wickets  out  4  wickets fallen.
- overs  out  5  completed overs.
- balls  out  3  legal balls in the current over, 0–5.
- innings_over  out  1  high in state DONE.
- ball_event  out  1  one-cycle strobe marking an accepted delivery.
- bad_input  out  1  one-cycle strobe marking a rejected delivery (run_sel = 7).

## Operation
- Synchroniser and edge detection:
  - debounced_button passes through 2 flops (s1, s2), then a history flop s3.
  - event = s2 & ~s3, so each press yields exactly one event however long the input stays high.
- Outcome inputs are sampled on the event cycle only; they are not synchronised and must be static switches.
- FSM states:
  - PLAY → DONE when wickets reaches MAX_WICKETS or overs reaches OVERS after an update.
  - DONE → PLAY only on new_innings.
  - new_innings from any state clears all counters and enters PLAY.
- Event in PLAY with run_sel = 7: no counter changes; bad_input pulses; ball_event stays low.
- Event in PLAY with extra = 1:
  - runs += 1 + run_sel.
  - balls, overs and wickets are unchanged; wicket is ignored.
  - ball_event pulses.
- Event in PLAY with extra = 0 (legal delivery):
  - runs += run_sel.
  - wickets += wicket.
  - balls increments; if balls was BALLS_PER_OVER−1, balls becomes 0 and overs increments.
  - ball_event pulses.
- Arithmetic: runs is computed in 11 bits and clamped at RUN_SAT; it never wraps. wickets and overs never exceed their limits.
- Event in DONE: ignored entirely, with no strobes.
- Simultaneous new_innings and event: the clear wins and the event is discarded.
- Reset values: runs 0, wickets 0, overs 0, balls 0, innings_over 0, ball_event 0, bad_input 0, s1/s2/s3 0, FSM in PLAY.
- Reset asserted mid-operation clears everything immediately (asynchronous). Reset release is not required to produce any event.

## Timing
- debounced_button first sampled high at clock edge 1.
- Event becomes valid after edge 2.
- Counters, FSM state, ball_event and bad_input update at edge 3; the strobes are high for exactly the cycle after edge 3.
- innings_over rises in the same cycle the final counter values appear.
- A new event needs debounced_button low for at least one sampled cycle before it rises again.
- new_innings takes effect on the next edge; outputs read zero the cycle after.

## Structure
- Shared package cricket_pkg:
  - Constants: OVERS, BALLS_PER_OVER, MAX_WICKETS, RUN_SAT.
  - The state enum with values PLAY and DONE.
  - Output widths, so the display stage uses the same values.
- Sub-module pulse_sync: 2-flop synchroniser plus rising-edge detector, with ports clk_fpga, reset_n, in, pulse. It is reusable for other board switches.
- Counters and the FSM live in ball_event_scorer itself.

## Test plan
- Reset, then one press with run_sel = 4, extra = 0, wicket = 0 → at edge 3: runs = 4, balls = 1, one-cycle ball_event.
- Six legal presses with run_sel = 1 → runs = 6, balls = 0, overs = 1. Hold debounced_button high for 10 000 cycles on one press → exactly one event.
- Press with extra = 1, run_sel = 2, wicket = 1 → runs += 3; balls and wickets unchanged.
- Ten legal presses with wicket = 1 → innings_over = 1. An 11th press leaves all outputs unchanged and produces no strobe.
- Preload runs = 998, then press with run_sel = 6 → runs = 999. Press with run_sel = 7 → bad_input pulses and no counter changes.
- new_innings asserted in the same cycle as an event → all counters 0 and state PLAY. Assert reset_n low mid-over → outputs 0 asynchronously.
